// File: rtl/sprite_pkg.sv
// Shared sprite-ROM geometry, default widths and the address packing helper
// used by the ROM arbiter and the per-sprite renderers.
package sprite_pkg;

  localparam int unsigned NSPRITES_DEFAULT = 8;
  localparam int unsigned SPR_SIZE_DEFAULT = 16;
  localparam int unsigned SW               = $clog2(NSPRITES_DEFAULT);
  localparam int unsigned CW               = $clog2(SPR_SIZE_DEFAULT);
  localparam int unsigned ADDR_W           = SW + 2 * CW;
  localparam int unsigned PIX_W            = 4;

  localparam logic [PIX_W-1:0] TRANSP_DEFAULT = 4'h0;

  typedef logic [ADDR_W-1:0] sprite_addr_t;

  // One pixel location inside the ROM, laid out exactly as the ROM address.
  typedef struct packed {
    logic [SW-1:0] spr;
    logic [CW-1:0] row;
    logic [CW-1:0] col;
  } sprite_loc_t;

  function automatic sprite_addr_t sprite_addr(
    input logic [SW-1:0] spr,
    input logic [CW-1:0] row,
    input logic [CW-1:0] col
  );
    sprite_loc_t loc;
    loc.spr = spr;
    loc.row = row;
    loc.col = col;
    return sprite_addr_t'(loc);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first active request at or above the
// pointer (with wrap), optionally with requester 0 pinned to top priority.
module rr_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter bit          PRIO0 = 1'b0,
  localparam int unsigned PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [PW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_gnt_c,
  output logic [PW-1:0]   o_win_c,
  output logic            o_any_c
);

  // Walk from the farthest candidate back to the pointer so the closest one wins.
  always_comb begin
    int unsigned v_idx;
    v_idx   = 0;
    o_any_c = |i_req;
    o_win_c = '0;
    for (int k = int'(NREQ) - 1; k >= 0; k--) begin
      v_idx = (32'(i_ptr) + 32'(k)) % NREQ;
      if (i_req[PW'(v_idx)]) begin
        o_win_c = PW'(v_idx);
      end
    end
    if (PRIO0 && i_req[0]) begin
      o_win_c = '0;
    end
  end

  always_comb begin
    o_gnt_c = '0;
    if (o_any_c) begin
      o_gnt_c[o_win_c] = 1'b1;
    end
  end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Shares the sprite ROM read port among NREQ renderers: one grant per cycle,
// packed {sprite,row,col} address, and a 2-stage tag pipe that routes each pixel home.
module sprite_rom_arbiter
  import sprite_pkg::*;
#(
  parameter int unsigned      NREQ     = 4,
  parameter int unsigned      NSPRITES = 8,
  parameter int unsigned      SPR_SIZE = 16,
  parameter logic [PIX_W-1:0] TRANSP   = TRANSP_DEFAULT,
  parameter bit               PRIO0    = 1'b0,
  localparam int unsigned SPR_W = $clog2(NSPRITES),
  localparam int unsigned CRD_W = $clog2(SPR_SIZE),
  localparam int unsigned AW    = SPR_W + 2 * CRD_W,
  localparam int unsigned PW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*SPR_W-1:0]   spr_id,
  input  logic [NREQ*CRD_W-1:0]   row,
  input  logic [NREQ*CRD_W-1:0]   col,
  output logic [NREQ-1:0]         gnt,
  output logic [NREQ-1:0]         rvalid,
  output logic [PIX_W-1:0]        pixel_o,
  output logic                    opaque_o,
  output logic [AW-1:0]           rom_add,
  input  logic [PIX_W-1:0]        rom_pixel
);

  logic [PW-1:0]   r_ptr;
  logic [AW-1:0]   r_add;
  logic [NREQ-1:0] r_tag1;
  logic [NREQ-1:0] r_tag2;

  logic [NREQ-1:0] w_gnt;
  logic [PW-1:0]   w_win;
  logic            w_any;
  logic [PW-1:0]   w_ptr_nxt;
  logic [AW-1:0]   w_add;

  logic [SPR_W-1:0] w_spr_a [NREQ];
  logic [CRD_W-1:0] w_row_a [NREQ];
  logic [CRD_W-1:0] w_col_a [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign w_spr_a[i] = spr_id[i*SPR_W +: SPR_W];
    assign w_row_a[i] = row[i*CRD_W +: CRD_W];
    assign w_col_a[i] = col[i*CRD_W +: CRD_W];
  end

  rr_arbiter #(
    .NREQ  (NREQ),
    .PRIO0 (PRIO0)
  ) u_rr (
    .i_req   (req),
    .i_ptr   (r_ptr),
    .o_gnt_c (w_gnt),
    .o_win_c (w_win),
    .o_any_c (w_any)
  );

  // Default geometry shares the renderers' packing helper; other sizes pack inline.
  if (SPR_W == SW && CRD_W == CW) begin : g_pkg_addr
    assign w_add = sprite_addr(w_spr_a[w_win], w_row_a[w_win], w_col_a[w_win]);
  end else begin : g_cat_addr
    assign w_add = {w_spr_a[w_win], w_row_a[w_win], w_col_a[w_win]};
  end

  // Pinned requester 0 does not advance the rotation.
  always_comb begin
    w_ptr_nxt = r_ptr;
    if (w_any && !(PRIO0 && (w_win == '0))) begin
      w_ptr_nxt = (w_win == PW'(NREQ - 1)) ? '0 : w_win + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ptr  <= '0;
      r_add  <= '0;
      r_tag1 <= '0;
      r_tag2 <= '0;
    end else begin
      r_ptr  <= w_ptr_nxt;
      r_tag1 <= w_gnt;
      r_tag2 <= r_tag1;
      if (w_any) begin
        r_add <= w_add;
      end
    end
  end

  assign gnt      = w_gnt;
  assign rvalid   = r_tag2;
  assign rom_add  = r_add;
  assign pixel_o  = rom_pixel;
  assign opaque_o = (|r_tag2) && (rom_pixel != TRANSP);

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Randomized bench for sprite_rom_arbiter against a queue-based reference model;
// one instance with rotating priority, one with requester 0 pinned.
module tb_sprite_rom_arbiter;

  typedef struct {
    int due;
    int who;
    int addr;
  } resp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn;
  logic [3:0]  req;
  logic [2:0]  spr_v [4];
  logic [3:0]  row_v [4];
  logic [3:0]  col_v [4];
  logic [11:0] spr_bus;
  logic [15:0] row_bus;
  logic [15:0] col_bus;

  for (genvar i = 0; i < 4; i++) begin : g_pack
    assign spr_bus[i*3 +: 3] = spr_v[i];
    assign row_bus[i*4 +: 4] = row_v[i];
    assign col_bus[i*4 +: 4] = col_v[i];
  end

  logic [3:0]  gnt0, rv0, pix0, rp0, gnt1, rv1, pix1, rp1;
  logic        opq0, opq1;
  logic [10:0] add0, add1;

  sprite_rom_arbiter #(.NREQ(4), .NSPRITES(8), .SPR_SIZE(16), .TRANSP(4'h0), .PRIO0(1'b0)) u_dut0 (
    .clk(clk), .rstn(rstn), .req(req), .spr_id(spr_bus), .row(row_bus), .col(col_bus),
    .gnt(gnt0), .rvalid(rv0), .pixel_o(pix0), .opaque_o(opq0), .rom_add(add0), .rom_pixel(rp0)
  );

  sprite_rom_arbiter #(.NREQ(4), .NSPRITES(8), .SPR_SIZE(16), .TRANSP(4'h0), .PRIO0(1'b1)) u_dut1 (
    .clk(clk), .rstn(rstn), .req(req), .spr_id(spr_bus), .row(row_bus), .col(col_bus),
    .gnt(gnt1), .rvalid(rv1), .pixel_o(pix1), .opaque_o(opq1), .rom_add(add1), .rom_pixel(rp1)
  );

  logic [3:0] rom [2048];
  always @(posedge clk) begin
    rp0 <= rom[add0];
    rp1 <= rom[add1];
  end

  logic        sel;
  logic [3:0]  o_gnt, o_rv, o_pix;
  logic        o_opq;
  logic [10:0] o_add;
  assign o_gnt = sel ? gnt1 : gnt0;
  assign o_rv  = sel ? rv1  : rv0;
  assign o_pix = sel ? pix1 : pix0;
  assign o_opq = sel ? opq1 : opq0;
  assign o_add = sel ? add1 : add0;

  int          n_chk, n_pass, cyc, m_ptr;
  bit          m_prio;
  logic [10:0] m_add;
  resp_t       q[$];
  logic [3:0]  exp_gnt, exp_rv, exp_pix;
  logic [10:0] exp_add;
  bit          exp_opq;
  string       tname;

  task automatic model_reset();
    q.delete();
    m_ptr = 0;
    m_add = '0;
  endtask

  // Expected outputs for the current cycle, then advance to the next one.
  task automatic model_cycle();
    int w;
    int a;
    resp_t r;
    w = -1;
    exp_add = m_add;
    if (req != 4'b0) begin
      if (m_prio && req[0]) w = 0;
      else
        for (int k = 0; k < 4; k++)
          if (w < 0 && req[2'((m_ptr + k) % 4)]) w = (m_ptr + k) % 4;
    end
    exp_gnt = (w >= 0) ? 4'(1 << w) : 4'b0;
    exp_rv  = 4'b0;
    exp_pix = 4'h0;
    exp_opq = 1'b0;
    if (q.size() > 0 && q[0].due == cyc) begin
      exp_rv  = 4'(1 << q[0].who);
      exp_pix = rom[11'(q[0].addr)];
      exp_opq = (exp_pix != 4'h0);
      void'(q.pop_front());
    end
    if (w >= 0) begin
      a = int'(spr_v[2'(w)]) * 256 + int'(row_v[2'(w)]) * 16 + int'(col_v[2'(w)]);
      r.due  = cyc + 2;
      r.who  = w;
      r.addr = a;
      q.push_back(r);
      m_add = 11'(a);
      if (!(m_prio && w == 0)) m_ptr = (w + 1) % 4;
    end
    cyc++;
  endtask

  task automatic cyc_model();
    @(negedge clk);
    model_cycle();
  endtask

  task automatic cyc_end();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_addrs();
    for (int i = 0; i < 4; i++) begin
      spr_v[i] = 3'($urandom);
      row_v[i] = 4'($urandom);
      col_v[i] = 4'($urandom);
    end
  endtask

  task automatic apply_reset();
    rstn = 1'b0;
    req  = 4'b0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    tname = "reset";
    @(negedge clk);
    n_chk++; if (rv0 !== 4'b0 || rv1 !== 4'b0) $display("FAIL %s rvalid: got %b/%b want 0000", tname, rv0, rv1); else n_pass++;
    n_chk++; if (opq0 !== 1'b0) $display("FAIL %s opaque: got %b want 0", tname, opq0); else n_pass++;
    n_chk++; if (add0 !== 11'h0) $display("FAIL %s rom_add: got %h want 000", tname, add0); else n_pass++;
    n_chk++; if (gnt0 !== 4'b0) $display("FAIL %s gnt idle: got %b want 0000", tname, gnt0); else n_pass++;
    req = 4'b1111;
    #1;
    n_chk++; if (gnt0 !== 4'b0001) $display("FAIL %s gnt comb: got %b want 0001", tname, gnt0); else n_pass++;
    req = 4'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    model_reset();
  endtask

  task automatic test_single();
    tname = "single";
    sel = 1'b0; m_prio = 1'b0;
    apply_reset();
    req = 4'b0001; spr_v[0] = 3'd2; row_v[0] = 4'd3; col_v[0] = 4'd5;
    cyc_model();
    n_chk++; if (o_gnt !== 4'b0001) $display("FAIL %s gnt: got %b want 0001", tname, o_gnt); else n_pass++;
    cyc_end();
    req = 4'b0;
    cyc_model();
    n_chk++; if (o_add !== 11'h235) $display("FAIL %s rom_add: got %h want 235", tname, o_add); else n_pass++;
    n_chk++; if (o_rv !== 4'b0) $display("FAIL %s rvalid T+1: got %b want 0000", tname, o_rv); else n_pass++;
    cyc_end();
    cyc_model();
    n_chk++; if (o_rv !== 4'b0001) $display("FAIL %s rvalid T+2: got %b want 0001", tname, o_rv); else n_pass++;
    n_chk++; if (o_pix !== rom[11'h235]) $display("FAIL %s pixel: got %h want %h", tname, o_pix, rom[11'h235]); else n_pass++;
    cyc_end();
  endtask

  task automatic test_all_four();
    tname = "all_four";
    sel = 1'b0; m_prio = 1'b0;
    apply_reset();
    for (int k = 0; k < 10; k++) begin
      req = (k < 8) ? 4'b1111 : 4'b0;
      rand_addrs();
      cyc_model();
      if (k < 8) begin
        n_chk++; if (o_gnt !== 4'(1 << (k % 4))) $display("FAIL %s gnt k=%0d: got %b want %b", tname, k, o_gnt, 4'(1 << (k % 4))); else n_pass++;
      end
      n_chk++; if (o_rv !== exp_rv) $display("FAIL %s rvalid k=%0d: got %b want %b", tname, k, o_rv, exp_rv); else n_pass++;
      if (exp_rv != 4'b0) begin
        n_chk++; if (o_pix !== exp_pix) $display("FAIL %s pixel k=%0d: got %h want %h", tname, k, o_pix, exp_pix); else n_pass++;
      end
      cyc_end();
    end
  endtask

  task automatic test_prio();
    tname = "prio0";
    sel = 1'b1; m_prio = 1'b1;
    apply_reset();
    for (int k = 0; k < 9; k++) begin
      req = (k < 6) ? 4'b0101 : ((k == 6) ? 4'b0100 : 4'b0);
      rand_addrs();
      cyc_model();
      if (k < 6) begin
        n_chk++; if (o_gnt !== 4'b0001) $display("FAIL %s gnt k=%0d: got %b want 0001", tname, k, o_gnt); else n_pass++;
      end else if (k == 6) begin
        n_chk++; if (o_gnt !== 4'b0100) $display("FAIL %s gnt after drop: got %b want 0100", tname, o_gnt); else n_pass++;
      end
      n_chk++; if (o_rv !== exp_rv) $display("FAIL %s rvalid k=%0d: got %b want %b", tname, k, o_rv, exp_rv); else n_pass++;
      cyc_end();
    end
    sel = 1'b0; m_prio = 1'b0;
  endtask

  task automatic test_reset_mid();
    tname = "reset_mid";
    sel = 1'b0; m_prio = 1'b0;
    apply_reset();
    req = 4'b1111;
    for (int k = 0; k < 2; k++) begin
      rand_addrs();
      cyc_model();
      n_chk++; if (o_gnt !== 4'(1 << k)) $display("FAIL %s gnt k=%0d: got %b want %b", tname, k, o_gnt, 4'(1 << k)); else n_pass++;
      cyc_end();
    end
    rstn = 1'b0;
    req  = 4'b0;
    model_reset();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_chk++; if (o_rv !== 4'b0) $display("FAIL %s rvalid in reset: got %b want 0000", tname, o_rv); else n_pass++;
      cyc_end();
    end
    rstn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc_model();
      n_chk++; if (o_rv !== 4'b0) $display("FAIL %s rvalid after reset: got %b want 0000", tname, o_rv); else n_pass++;
      cyc_end();
    end
    req = 4'b1111;
    rand_addrs();
    cyc_model();
    n_chk++; if (o_gnt !== 4'b0001) $display("FAIL %s first gnt: got %b want 0001", tname, o_gnt); else n_pass++;
    cyc_end();
    req = 4'b0;
    for (int k = 0; k < 3; k++) begin
      cyc_model();
      n_chk++; if (o_rv !== exp_rv) $display("FAIL %s drain rvalid: got %b want %b", tname, o_rv, exp_rv); else n_pass++;
      cyc_end();
    end
  endtask

  task automatic test_transparency();
    tname = "transp";
    sel = 1'b0; m_prio = 1'b0;
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      req = (k < 2) ? 4'b0001 : 4'b0;
      spr_v[0] = 3'd0; row_v[0] = 4'd0; col_v[0] = 4'(k);
      cyc_model();
      if (k >= 2) begin
        n_chk++; if (o_rv !== 4'b0001) $display("FAIL %s rvalid k=%0d: got %b want 0001", tname, k, o_rv); else n_pass++;
        n_chk++; if (o_opq !== (k == 3)) $display("FAIL %s opaque k=%0d: got %b want %b", tname, k, o_opq, (k == 3)); else n_pass++;
        n_chk++; if (o_pix !== ((k == 3) ? 4'h7 : 4'h0)) $display("FAIL %s pixel k=%0d: got %h", tname, k, o_pix); else n_pass++;
      end
      cyc_end();
    end
  endtask

  task automatic test_withdrawn();
    tname = "withdrawn";
    sel = 1'b0; m_prio = 1'b0;
    apply_reset();
    rand_addrs();
    req = 4'b1010;
    cyc_model();
    n_chk++; if (o_gnt !== 4'b0010) $display("FAIL %s gnt: got %b want 0010", tname, o_gnt); else n_pass++;
    cyc_end();
    req = 4'b0;
    for (int k = 1; k < 5; k++) begin
      cyc_model();
      n_chk++; if (o_rv[3] !== 1'b0) $display("FAIL %s rvalid3 k=%0d: got %b want 0", tname, k, o_rv[3]); else n_pass++;
      if (k == 2) begin
        n_chk++; if (o_rv !== 4'b0010) $display("FAIL %s rvalid1: got %b want 0010", tname, o_rv); else n_pass++;
      end
      cyc_end();
    end
  endtask

  task automatic test_random(input bit prio);
    tname = prio ? "random_prio" : "random_rr";
    sel = prio; m_prio = prio;
    apply_reset();
    for (int k = 0; k < 300; k++) begin
      req = (k < 296) ? 4'($urandom) : 4'b0;
      rand_addrs();
      cyc_model();
      n_chk++; if (o_gnt !== exp_gnt) $display("FAIL %s gnt k=%0d: got %b want %b", tname, k, o_gnt, exp_gnt); else n_pass++;
      n_chk++; if (o_rv !== exp_rv) $display("FAIL %s rvalid k=%0d: got %b want %b", tname, k, o_rv, exp_rv); else n_pass++;
      n_chk++; if (o_opq !== exp_opq) $display("FAIL %s opaque k=%0d: got %b want %b", tname, k, o_opq, exp_opq); else n_pass++;
      n_chk++; if (o_add !== exp_add) $display("FAIL %s rom_add k=%0d: got %h want %h", tname, k, o_add, exp_add); else n_pass++;
      if (exp_rv != 4'b0) begin
        n_chk++; if (o_pix !== exp_pix) $display("FAIL %s pixel k=%0d: got %h want %h", tname, k, o_pix, exp_pix); else n_pass++;
      end
      cyc_end();
    end
    sel = 1'b0; m_prio = 1'b0;
  endtask

  initial begin
    n_chk = 0; n_pass = 0; cyc = 0;
    sel = 1'b0; m_prio = 1'b0;
    rstn = 1'b1;
    req = 4'b0;
    for (int i = 0; i < 4; i++) begin
      spr_v[i] = 3'd0; row_v[i] = 4'd0; col_v[i] = 4'd0;
    end
    for (int i = 0; i < 2048; i++) rom[i] = 4'($urandom);
    rom[0] = 4'h0;
    rom[1] = 4'h7;
    model_reset();
    #2 rstn = 1'b0;
    test_reset();
    test_single();
    test_all_four();
    test_prio();
    test_reset_mid();
    test_transparency();
    test_withdrawn();
    test_random(1'b0);
    test_random(1'b1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
